// File: rtl/arrow_scroller.sv
// Falling-arrow generator for the 16x16 LED matrix: four lanes scroll down one row
// per tick, key presses are judged at the bottom row, and score/miss totals are kept.
module arrow_scroller #(
    parameter int          TICK_DIV  = 25000000,
    parameter int          MAX_MISS  = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              run,
    input  logic [3:0]        key,
    input  logic [3:0]        inject,
    output logic [15:0][15:0] arrow_pixels,
    output logic              hit,
    output logic              miss,
    output logic [7:0]        score,
    output logic [3:0]        misses,
    output logic              game_over
);

    localparam int             CW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [3:0]     MISS_LIM  = 4'(MAX_MISS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PLAY = 2'd1;
    localparam logic [1:0] OVER = 2'd2;

    logic [1:0]       state_reg, state_next;
    logic [15:0][3:0] occ_reg, occ_next;
    logic [7:0]       score_reg, score_next;
    logic [3:0]       misses_reg, misses_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [15:0]      lfsr_reg, lfsr_next;
    logic             hit_reg, hit_next;
    logic             miss_reg, miss_next;

    logic [15:0][3:0] occ_judged, occ_upd;
    logic [3:0]       hit_mask, miss_mask, spawn;
    logic [8:0]       score_sum;
    logic [4:0]       miss_sum;
    logic [7:0]       score_upd;
    logic [3:0]       misses_upd;
    logic [15:0]      lfsr_upd;
    logic             tick;

    function automatic logic [2:0] popcnt4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    always_ff @(posedge clk) begin
        if (RST) begin
            state_reg  <= IDLE;
            occ_reg    <= '0;
            score_reg  <= '0;
            misses_reg <= '0;
            cnt_reg    <= '0;
            lfsr_reg   <= LFSR_SEED;
            hit_reg    <= 1'b0;
            miss_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            occ_reg    <= occ_next;
            score_reg  <= score_next;
            misses_reg <= misses_next;
            cnt_reg    <= cnt_next;
            lfsr_reg   <= lfsr_next;
            hit_reg    <= hit_next;
            miss_reg   <= miss_next;
        end
    end

    // Key judging happens first so a press in the tick cycle rescues the arrow.
    always_comb begin
        tick       = (cnt_reg == TICK_LAST);
        hit_mask   = key & occ_reg[15];
        occ_judged = occ_reg;
        occ_judged[15] = occ_reg[15] & ~key;
        score_sum  = {1'b0, score_reg} + {6'd0, popcnt4(hit_mask)};
        score_upd  = score_sum[8] ? 8'hFF : score_sum[7:0];
        miss_mask  = tick ? occ_judged[15] : 4'b0000;
        miss_sum   = {1'b0, misses_reg} + {2'd0, popcnt4(miss_mask)};
        misses_upd = miss_sum[4] ? 4'hF : miss_sum[3:0];
        spawn      = (lfsr_reg[2] ? (4'b0001 << lfsr_reg[1:0]) : 4'b0000) | inject;
        lfsr_upd   = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
        occ_upd    = tick ? {occ_judged[14:0], spawn} : occ_judged;
    end

    always_comb begin
        state_next  = state_reg;
        occ_next    = occ_reg;
        score_next  = score_reg;
        misses_next = misses_reg;
        cnt_next    = cnt_reg;
        lfsr_next   = lfsr_reg;
        hit_next    = 1'b0;
        miss_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                occ_next = '0;
                cnt_next = '0;
                if (run) begin
                    state_next  = PLAY;
                    score_next  = '0;
                    misses_next = '0;
                end
            end
            PLAY: begin
                if (!run) begin
                    state_next = IDLE;
                    occ_next   = '0;
                    cnt_next   = '0;
                end else begin
                    occ_next    = occ_upd;
                    score_next  = score_upd;
                    misses_next = misses_upd;
                    hit_next    = |hit_mask;
                    miss_next   = |miss_mask;
                    cnt_next    = tick ? '0 : cnt_reg + 1'b1;
                    lfsr_next   = tick ? lfsr_upd : lfsr_reg;
                    if (misses_upd >= MISS_LIM) begin
                        state_next = OVER;
                        occ_next   = '0;
                    end
                end
            end
            OVER: begin
                occ_next = '0;
                cnt_next = '0;
                if (!run) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                occ_next   = '0;
                cnt_next   = '0;
            end
        endcase
    end

    // Each lane is drawn two pixels wide in the middle of its 4-column slot.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_row
            assign arrow_pixels[gi] = {1'b0, occ_reg[gi][3], occ_reg[gi][3], 1'b0,
                                       1'b0, occ_reg[gi][2], occ_reg[gi][2], 1'b0,
                                       1'b0, occ_reg[gi][1], occ_reg[gi][1], 1'b0,
                                       1'b0, occ_reg[gi][0], occ_reg[gi][0], 1'b0};
        end
    endgenerate

    assign hit       = hit_reg;
    assign miss      = miss_reg;
    assign score     = score_reg;
    assign misses    = misses_reg;
    assign game_over = (state_reg == OVER);

endmodule

// File: tb/tb_arrow_scroller.sv
// Directed bench for arrow_scroller: instance A (seed 0, MAX_MISS 2) for scroll/hit/miss/
// game-over, instance B (default seed) for the random spawn sequence.
module tb_arrow_scroller;

    logic              clk = 1'b0;
    logic              RST;
    logic              run;
    logic [3:0]        key;
    logic [3:0]        inject;
    logic [15:0][15:0] pix_a, pix_b;
    logic              hit_a, miss_a, go_a, hit_b, miss_b, go_b;
    logic [7:0]        score_a, score_b;
    logic [3:0]        misses_a, misses_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    arrow_scroller #(.TICK_DIV(4), .MAX_MISS(2), .LFSR_SEED(16'h0000)) dut_a (
        .clk(clk), .RST(RST), .run(run), .key(key), .inject(inject),
        .arrow_pixels(pix_a), .hit(hit_a), .miss(miss_a), .score(score_a),
        .misses(misses_a), .game_over(go_a)
    );

    arrow_scroller #(.TICK_DIV(4), .MAX_MISS(15), .LFSR_SEED(16'hACE1)) dut_b (
        .clk(clk), .RST(RST), .run(run), .key(key), .inject(inject),
        .arrow_pixels(pix_b), .hit(hit_b), .miss(miss_b), .score(score_b),
        .misses(misses_b), .game_over(go_b)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] prow(input logic [3:0] m);
        logic [15:0] r;
        r = '0;
        for (int l = 0; l < 4; l++) begin
            r[4*l+2] = m[l];
            r[4*l+1] = m[l];
        end
        return r;
    endfunction

    function automatic logic [255:0] grid(input int row, input logic [3:0] m);
        logic [15:0][15:0] g;
        g = '0;
        g[row] = prow(m);
        return g;
    endfunction

    function automatic logic [3:0] spawn_of(input logic [15:0] l);
        logic [3:0] s;
        s = 4'b0000;
        if (l[2]) s[l[1:0]] = 1'b1;
        return s;
    endfunction

    function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic int pop4(input logic [3:0] v);
        return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
    endfunction

    // Leaves A/B in PLAY just after tick 1, with mask spawned into row 0.
    task automatic start_play(input logic [3:0] mask);
        run = 1'b0; key = 4'b0000; inject = 4'b0000;
        step();
        run = 1'b1; inject = mask;
        step();
        repeat (4) step();
        inject = 4'b0000;
    endtask

    logic [3:0]  sp [1:64];
    logic [15:0] lf;
    logic [3:0]  kp;
    int          exp_score;

    initial begin
        // Reset with arbitrary inputs
        RST = 1'b1; run = 1'b1; key = 4'b1111; inject = 4'b1010;
        repeat (2) step();
        check("rst_pix", pix_a, '0);
        check("rst_hit_miss", {hit_a, miss_a}, 2'b00);
        check("rst_score", score_a, 8'd0);
        check("rst_misses", misses_a, 4'd0);
        check("rst_game_over", go_a, 1'b0);
        RST = 1'b0; run = 1'b0; key = 4'b0000; inject = 4'b0000;
        step();

        // Single arrow walks the full height, then is missed on tick 17
        start_play(4'b0001);
        check("walk_row0", pix_a, grid(0, 4'b0001));
        for (int k = 1; k < 16; k++) begin
            repeat (4) step();
            check($sformatf("walk_row%0d", k), pix_a, grid(k, 4'b0001));
        end
        repeat (4) step();
        check("walk_miss_pulse", miss_a, 1'b1);
        check("walk_misses", misses_a, 4'd1);
        check("walk_empty", pix_a, '0);
        step();
        check("walk_miss_once", miss_a, 1'b0);

        // Hit at the bottom row, empty-lane key ignored
        start_play(4'b0001);
        repeat (60) step();
        check("hit_at15", pix_a, grid(15, 4'b0001));
        key = 4'b1000; step(); key = 4'b0000;
        check("empty_lane_score", score_a, 8'd0);
        check("empty_lane_hit", hit_a, 1'b0);
        key = 4'b0001; step(); key = 4'b0000;
        check("hit_pulse", hit_a, 1'b1);
        check("hit_score", score_a, 8'd1);
        check("hit_cleared", pix_a, '0);
        step();
        check("hit_once", hit_a, 1'b0);
        step();
        check("hit_no_miss", miss_a, 1'b0);
        check("hit_misses", misses_a, 4'd0);

        // Press lands in the same cycle as the tick that would miss
        start_play(4'b0001);
        repeat (63) step();
        key = 4'b0001; step(); key = 4'b0000;
        check("same_hit", hit_a, 1'b1);
        check("same_miss", miss_a, 1'b0);
        check("same_score", score_a, 8'd1);
        check("same_misses", misses_a, 4'd0);
        check("same_empty", pix_a, '0);

        // Two misses on one tick exhaust MAX_MISS=2
        start_play(4'b0011);
        repeat (60) step();
        check("over_at15", pix_a, grid(15, 4'b0011));
        repeat (4) step();
        check("over_miss_pulse", miss_a, 1'b1);
        check("over_misses", misses_a, 4'd2);
        check("over_flag", go_a, 1'b1);
        check("over_empty", pix_a, '0);
        key = 4'b1111; inject = 4'b1111;
        repeat (8) step();
        key = 4'b0000; inject = 4'b0000;
        check("over_frozen_pix", pix_a, '0);
        check("over_frozen_misses", misses_a, 4'd2);
        check("over_frozen_score", score_a, 8'd0);
        check("over_still", go_a, 1'b1);
        run = 1'b0; step();
        check("over_exit", go_a, 1'b0);
        check("over_exit_misses", misses_a, 4'd2);

        // Reset mid-play with arrows on screen and a non-zero score
        start_play(4'b1111);
        repeat (56) step();
        inject = 4'b0010;
        repeat (4) step();
        inject = 4'b0000;
        key = 4'b1111; step(); key = 4'b0000;
        check("mid_score4", score_a, 8'd4);
        check("mid_pix", pix_a, grid(0, 4'b0010));
        RST = 1'b1; step();
        check("mid_rst_pix", pix_a, '0);
        check("mid_rst_score", score_a, 8'd0);
        check("mid_rst_misses", misses_a, 4'd0);
        check("mid_rst_over", go_a, 1'b0);

        // Random spawns from the default seed over 64 ticks, all hit
        run = 1'b0; key = 4'b0000; inject = 4'b0000;
        step();
        RST = 1'b0;
        lf = 16'hACE1;
        exp_score = 0;
        run = 1'b1;
        step();
        for (int k = 1; k <= 64; k++) begin
            kp = (k >= 17) ? sp[k-16] : 4'b0000;
            exp_score += pop4(kp);
            key = kp; step(); key = 4'b0000;
            repeat (3) step();
            sp[k] = spawn_of(lf);
            lf = lfsr_adv(lf);
            check($sformatf("lfsr_row0_t%0d", k), pix_b[0], prow(sp[k]));
            if (k >= 16)
                check($sformatf("lfsr_row15_t%0d", k), pix_b[15], prow(sp[k-15]));
        end
        check("lfsr_score", score_b, 8'(exp_score));
        check("lfsr_misses", misses_b, 4'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
